// File: rtl/irrigation_zone_controller_if.sv
// Sensor/request inputs and valve/status outputs of the irrigation zone controller.
// The controller takes the slave side; the plant or its model takes the master side.
interface irrigation_zone_controller_if #(
    parameter int LEVEL_BITS = 4,
    parameter int NUM_ZONES  = 2
);
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

    logic [LEVEL_BITS-1:0] water_tank_level;
    logic [NUM_ZONES-1:0]  irrigation_req;
    logic [1:0]            state;
    logic                  valve_fill;
    logic [NUM_ZONES-1:0]  valve_zone;
    logic [ZW-1:0]         active_zone;
    logic                  zone_done;
    logic                  fault;

    modport master (
        output water_tank_level,
        output irrigation_req,
        input  state,
        input  valve_fill,
        input  valve_zone,
        input  active_zone,
        input  zone_done,
        input  fault
    );

    modport slave (
        input  water_tank_level,
        input  irrigation_req,
        output state,
        output valve_fill,
        output valve_zone,
        output active_zone,
        output zone_done,
        output fault
    );
endinterface

// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation FSM: tank refill, round-robin timed zone slots,
// resume of an interrupted zone after refill, sticky FAULT on bad sensor codes.
module irrigation_zone_controller #(
    parameter int LEVEL_BITS = 4,
    parameter int NUM_ZONES  = 2,
    parameter int MIN_LEVEL  = 0,
    parameter int FULL_LEVEL = 3,
    parameter int ZONE_TIME  = 8
) (
    input  logic                         clk,
    input  logic                         initialize,
    irrigation_zone_controller_if.slave  bus
);
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int TW = (ZONE_TIME > 1) ? $clog2(ZONE_TIME) : 1;
    localparam logic [ZW-1:0] LAST_ZONE = ZW'(NUM_ZONES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(ZONE_TIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FILL     = 2'b01,
        ST_IRRIGATE = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [ZW-1:0]   zone_q, zone_d;
    logic [ZW-1:0]   rr_q, rr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            done_q, done_d;
    logic            resume_q, resume_d;

    logic [LEVEL_BITS-1:0] lvl;
    logic [NUM_ZONES-1:0]  req;
    logic                  level_ok;
    logic                  at_min;
    logic                  at_full;
    logic [ZW:0]           sel_rr;
    logic [ZW:0]           sel_next;

    function automatic logic [ZW-1:0] next_zone(input logic [ZW-1:0] z);
        return (z == LAST_ZONE) ? '0 : z + ZW'(1);
    endfunction

    // Returns {found, zone}: first requesting zone at or after start, wrapping.
    function automatic logic [ZW:0] select_zone(
        input logic [ZW-1:0]        start,
        input logic [NUM_ZONES-1:0] r
    );
        logic [ZW-1:0] z;
        logic [ZW-1:0] pick;
        logic          found;
        z     = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_ZONES; k++) begin
            if (!found && r[z]) begin
                found = 1'b1;
                pick  = z;
            end
            z = next_zone(z);
        end
        return {found, pick};
    endfunction

    assign lvl      = bus.water_tank_level;
    assign req      = bus.irrigation_req;
    // A thermometer code plus one carries into the first clear bit only.
    assign level_ok = ((lvl & (lvl + LEVEL_BITS'(1))) == '0);
    assign at_min   = lvl[MIN_LEVEL];
    assign at_full  = lvl[FULL_LEVEL];
    assign sel_rr   = select_zone(rr_q, req);
    assign sel_next = select_zone(next_zone(zone_q), req);

    always_comb begin
        state_d  = state_q;
        zone_d   = zone_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
        resume_d = resume_q;
        if (!level_ok) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_rr[ZW]) begin
                        if (at_min) begin
                            state_d = ST_IRRIGATE;
                            zone_d  = sel_rr[ZW-1:0];
                            timer_d = '0;
                        end else begin
                            state_d  = ST_FILL;
                            resume_d = 1'b0;
                        end
                    end
                end
                ST_FILL: begin
                    if (at_full) begin
                        resume_d = 1'b0;
                        if (resume_q && req[zone_q]) begin
                            state_d = ST_IRRIGATE;
                        end else if (sel_rr[ZW]) begin
                            state_d = ST_IRRIGATE;
                            zone_d  = sel_rr[ZW-1:0];
                            timer_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_IRRIGATE: begin
                    if (!at_min) begin
                        state_d  = ST_FILL;
                        resume_d = 1'b1;
                    end else if (timer_q == LAST_TICK || !req[zone_q]) begin
                        done_d = 1'b1;
                        rr_d   = next_zone(zone_q);
                        if (sel_next[ZW]) begin
                            zone_d  = sel_next[ZW-1:0];
                            timer_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (initialize) begin
            state_q  <= ST_IDLE;
            zone_q   <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            zone_q   <= zone_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            resume_q <= resume_d;
        end
    end

    always_comb begin
        bus.valve_zone = '0;
        if (state_q == ST_IRRIGATE) begin
            bus.valve_zone[zone_q] = 1'b1;
        end
    end

    assign bus.state       = state_q;
    assign bus.valve_fill  = (state_q == ST_FILL);
    assign bus.active_zone = zone_q;
    assign bus.zone_done   = done_q;
    assign bus.fault       = (state_q == ST_FAULT);
endmodule
